// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bp_pkg
// Description : Shared encodings, constants and BTB entry type for the
//               branch-prediction controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // 2-bit direction counter encodings
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Counters start weakly not-taken so one taken outcome flips the prediction
  localparam logic [1:0] CNT_RESET = WNT;

  // Sequential fetch increment
  localparam int PC_INC = 4;

  // Widest PC the shared entry type can hold; narrower PCs are zero-extended
  localparam int BP_MAX_PC_W = 64;

  typedef struct packed {
    logic                   valid;
    logic [BP_MAX_PC_W-1:0] tag;
    logic [BP_MAX_PC_W-1:0] target;
  } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter2
// Description : Next-state function of a 2-bit saturating direction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  // Step toward the resolved direction, holding at either end
  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_ctrl
// Description : Fetch-steering controller. 2-bit-counter BHT plus direct-mapped
//               BTB predict next PC in IF; EX outcomes resolve predictions,
//               raise flush/redirect and train the tables. Keeps statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int BIDX_W = $clog2(BHT_ENTRIES);
  localparam int TIDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = PC_W - TIDX_W - 2;
  localparam logic [PC_W-1:0]  INC      = PC_W'(PC_INC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0] bht [BHT_ENTRIES];
  btb_entry_t btb [BTB_ENTRIES];

  logic [BIDX_W-1:0] if_bidx, ex_bidx;
  logic [TIDX_W-1:0] if_tidx, ex_tidx;
  logic [TAG_W-1:0]  if_tag,  ex_tag;
  logic              if_hit;
  logic              br_mispredict, alias_mispredict;
  logic              train, alias_clear;
  logic [1:0]        ctr_next;
  logic              unused_pc_lsbs;

  assign if_bidx = if_pc[BIDX_W+1:2];
  assign if_tidx = if_pc[TIDX_W+1:2];
  assign if_tag  = if_pc[PC_W-1:TIDX_W+2];
  assign ex_bidx = ex_pc[BIDX_W+1:2];
  assign ex_tidx = ex_pc[TIDX_W+1:2];
  assign ex_tag  = ex_pc[PC_W-1:TIDX_W+2];

  // Word-aligned PCs: the byte-offset bits never take part in indexing
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  // IF lookup reads the tables as they stand; an EX update in the same cycle
  // becomes visible only after the clock edge
  assign if_hit      = btb[if_tidx].valid && (btb[if_tidx].tag == BP_MAX_PC_W'(if_tag));
  assign pred_taken  = !rst && if_valid && if_hit && bht[if_bidx][1];
  assign pred_target = pred_taken ? btb[if_tidx].target[PC_W-1:0] : if_pc + INC;

  // A non-branch predicted taken means the BTB matched a stale/aliased entry
  assign br_mispredict    = ex_is_branch && ((ex_pred_taken != ex_taken) ||
                            (ex_taken && (ex_pred_target != ex_target)));
  assign alias_mispredict = !ex_is_branch && ex_pred_taken;
  assign flush            = !rst && ex_valid && (br_mispredict || alias_mispredict);
  assign redirect_pc      = (ex_is_branch && ex_taken) ? ex_target : ex_pc + INC;

  assign train       = ex_valid && ex_is_branch;
  assign alias_clear = ex_valid && !ex_is_branch && ex_pred_taken;

  bp_sat_counter2 u_ctr (
    .cnt      (bht[ex_bidx]),
    .taken    (ex_taken),
    .cnt_next (ctr_next)
  );

  // BHT: reset all counters to weakly not-taken, else train on resolved branches
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_RESET;
    end else if (train) begin
      bht[ex_bidx] <= ctr_next;
    end
  end

  // BTB: install taken branches, drop entries that aliased onto a non-branch
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb[i].valid <= 1'b0;
    end else if (train && ex_taken) begin
      btb[ex_tidx].valid  <= 1'b1;
      btb[ex_tidx].tag    <= BP_MAX_PC_W'(ex_tag);
      btb[ex_tidx].target <= BP_MAX_PC_W'(ex_target);
    end else if (alias_clear) begin
      btb[ex_tidx].valid <= 1'b0;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (train && (stat_branches != '1))    stat_branches    <= stat_branches + CNT_ONE;
      if (flush && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_pred_ctrl
// Description : Self-checking bench for branch_pred_ctrl (vector table plus
//               hand-written reset sequence, scoreboard-queue comparison).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pred_ctrl;

  localparam logic [31:0] A  = 32'h40;
  localparam logic [31:0] T  = 32'h80;
  localparam logic [31:0] A4 = 32'h44;

  typedef struct {
    logic        rst, iv;
    logic [31:0] ipc;
    logic        ev, eb;
    logic [31:0] epc;
    logic        et;
    logic [31:0] etg;
    logic        ept;
    logic [31:0] eptg;
    logic        xpt;
    logic [31:0] xtg;
    logic        xfl;
    logic [31:0] xrd;
    logic        cs;
    logic [31:0] xb, xm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, if_valid, ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
  logic        pred_taken, flush;
  logic [31:0] pred_target, redirect_pc, stat_branches, stat_mispredicts;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  branch_pred_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  function automatic vec_t vec(
    input logic r, iv, input logic [31:0] ipc,
    input logic ev, eb, input logic [31:0] epc, input logic et, input logic [31:0] etg,
    input logic ept, input logic [31:0] eptg,
    input logic xpt, input logic [31:0] xtg, input logic xfl, input logic [31:0] xrd,
    input logic cs, input logic [31:0] xb, xm);
    vec_t v;
    v.rst = r;  v.iv = iv;  v.ipc = ipc;
    v.ev = ev;  v.eb = eb;  v.epc = epc; v.et = et; v.etg = etg;
    v.ept = ept; v.eptg = eptg;
    v.xpt = xpt; v.xtg = xtg; v.xfl = xfl; v.xrd = xrd;
    v.cs = cs;  v.xb = xb;  v.xm = xm;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (at %0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare once settled
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; if_valid = v.iv; if_pc = v.ipc;
    ex_valid = v.ev; ex_is_branch = v.eb; ex_pc = v.epc;
    ex_taken = v.et; ex_target = v.etg;
    ex_pred_taken = v.ept; ex_pred_target = v.eptg;
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    check("pred_taken",  {31'd0, pred_taken}, {31'd0, e.xpt});
    check("pred_target", pred_target, e.xtg);
    check("flush",       {31'd0, flush}, {31'd0, e.xfl});
    if (e.xfl) check("redirect_pc", redirect_pc, e.xrd);
    if (e.cs) begin
      check("stat_branches",    stat_branches,    e.xb);
      check("stat_mispredicts", stat_mispredicts, e.xm);
    end
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_is_branch = 1'b0;
    ex_pc = '0; ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

    //                rst iv ipc           ev eb epc           et etg        ept eptg  xpt xtg   xfl xrd  cs xb xm
    tbl.push_back(vec(1, 0, A,            0, 0, 0,            0, 0,         0, 0,     0, A4,   0, 0,    0, 0, 0));
    tbl.push_back(vec(1, 1, A,            1, 1, A,            1, T,         0, 0,     0, A4,   0, 0,    1, 0, 0));
    tbl.push_back(vec(0, 1, A,            0, 0, 0,            0, 0,         0, 0,     0, A4,   0, 0,    1, 0, 0));
    tbl.push_back(vec(0, 1, A,            1, 1, A,            1, T,         0, 0,     0, A4,   1, T,    1, 0, 0));
    tbl.push_back(vec(0, 1, A,            0, 0, 0,            0, 0,         0, 0,     1, T,    0, 0,    1, 1, 1));
    tbl.push_back(vec(0, 1, A,            1, 1, A,            1, T,         1, T,     1, T,    0, 0,    1, 1, 1));
    tbl.push_back(vec(0, 1, A,            1, 1, A,            1, T,         1, T,     1, T,    0, 0,    1, 2, 1));
    tbl.push_back(vec(0, 1, A,            1, 1, A,            1, T,         1, T,     1, T,    0, 0,    1, 3, 1));
    tbl.push_back(vec(0, 1, A,            1, 1, A,            0, 0,         1, T,     1, T,    1, A4,   1, 4, 1));
    tbl.push_back(vec(0, 1, A,            0, 0, 0,            0, 0,         0, 0,     1, T,    0, 0,    1, 5, 2));
    tbl.push_back(vec(0, 1, A,            1, 0, 32'h80,       0, 0,         1, T,     1, T,    1, 32'h84, 1, 5, 2));
    tbl.push_back(vec(0, 1, A,            0, 0, 0,            0, 0,         0, 0,     0, A4,   0, 0,    1, 5, 3));
    tbl.push_back(vec(0, 1, A,            1, 1, A,            1, T,         0, 0,     0, A4,   1, T,    1, 5, 3));
    tbl.push_back(vec(0, 1, A,            0, 0, 0,            0, 0,         0, 0,     1, T,    0, 0,    1, 6, 4));
    tbl.push_back(vec(0, 1, A,            1, 1, A,            1, 32'h100,   1, T,     1, T,    1, 32'h100, 1, 6, 4));
    tbl.push_back(vec(0, 1, A,            0, 0, 0,            0, 0,         0, 0,     1, 32'h100, 0, 0, 1, 7, 5));
    tbl.push_back(vec(0, 0, A,            0, 0, 0,            0, 0,         0, 0,     0, A4,   0, 0,    1, 7, 5));
    tbl.push_back(vec(0, 1, A,            1, 0, 32'h200,      0, 0,         0, 0,     1, 32'h100, 0, 0, 1, 7, 5));
    tbl.push_back(vec(0, 1, A,            0, 1, A,            1, T,         0, 0,     1, 32'h100, 0, 0, 1, 7, 5));
    tbl.push_back(vec(0, 1, 32'hFFFFFFFC, 1, 0, 32'hFFFFFFFC, 0, 0,         1, 0,     0, 0,    1, 0,    1, 7, 5));
    tbl.push_back(vec(0, 1, A,            0, 0, 0,            0, 0,         0, 0,     1, 32'h100, 0, 0, 1, 7, 6));

    foreach (tbl[i]) step(tbl[i]);

    // Reset lands on a mispredicting branch: no flush, no update, tables cleared
    step(vec(1, 1, A, 1, 1, A, 0, 0, 1, 32'h100, 0, A4, 0, 0, 1, 7, 6));
    step(vec(0, 1, A, 0, 0, 0, 0, 0, 0, 0,       0, A4, 0, 0, 1, 0, 0));
    // One taken outcome from reset predicts taken; one not-taken drops it back
    step(vec(0, 1, A, 1, 1, A, 1, T, 0, 0,       0, A4, 1, T,  1, 0, 0));
    step(vec(0, 1, A, 0, 0, 0, 0, 0, 0, 0,       1, T,  0, 0,  1, 1, 1));
    step(vec(0, 1, A, 1, 1, A, 0, 0, 1, T,       1, T,  1, A4, 1, 1, 1));
    step(vec(0, 1, A, 0, 0, 0, 0, 0, 0, 0,       0, A4, 0, 0,  1, 2, 2));
    // Saturate at strongly not-taken, then one taken must only reach weakly not-taken
    step(vec(0, 1, A, 1, 1, A, 0, 0, 0, 0,       0, A4, 0, 0,  1, 2, 2));
    step(vec(0, 1, A, 1, 1, A, 0, 0, 0, 0,       0, A4, 0, 0,  1, 3, 2));
    step(vec(0, 1, A, 1, 1, A, 1, T, 0, 0,       0, A4, 1, T,  1, 4, 2));
    step(vec(0, 1, A, 0, 0, 0, 0, 0, 0, 0,       0, A4, 0, 0,  1, 5, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
